// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg: shared constants and types for the instruction fetch slice.
//   XLEN / INSTR_BYTES : machine word width and instruction size in bytes
//   DEFAULT_RESET_PC   : PC loaded on reset unless overridden
//   fetch_entry_t      : {pc, instr} pair held in the fetch buffer
//   fetch_state_e      : fetch FSM states (RUN, HALT)
//   word_align()       : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Masking (rather than slicing) keeps every address bit in use.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo: synchronous circular buffer of fetch entries.
//   clk, rst : clock, asynchronous active-high reset of pointers/count
//   push     : write din at the tail (ignored when full unless pop is set)
//   pop      : release the head (ignored when empty)
//   flush    : discard all entries; wins over push
//   din/dout : entry written / entry at the head (undefined when empty)
//   count    : number of stored entries, full/empty flags
// BUF_DEPTH must be a power of two and at least 2 so the pointers wrap by
// simple overflow.
// ---------------------------------------------------------------------------
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic [$clog2(BUF_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_p0 [BUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(BUF_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_p0[rd_ptr];
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && !flush && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Storage stage: entry data carries no reset, emptiness is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_p0[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch: fetch stage driving a combinational instruction memory.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_pc         : address presented to instruction memory (pc register)
//   imem_instr      : word at imem_pc, same cycle
//   redirect_valid  : taken branch/jump; flushes the buffer, loads redirect_pc
//   redirect_pc     : redirect target (byte offset bits ignored)
//   out_valid/ready : valid/ready handshake towards decode
//   out_instr/out_pc/out_pc_plus4 : head entry (last popped entry when empty)
//   halted          : fetch stopped at end of memory and buffer drained
// Optional build macro FETCH_PERF_EN adds saturating counters:
//   perf_fetched    : number of fetches
//   perf_stall      : cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 64,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  // One extra bit so the end-of-memory bound cannot overflow.
  localparam logic [XLEN:0] PC_LIMIT =
    (XLEN+1)'(longint'(IMEM_WORDS) * longint'(INSTR_BYTES));
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc_p0;
  fetch_state_e    state_p0;
  fetch_entry_t    head_p1;
  fetch_entry_t    last_p1;
  fetch_entry_t    fetch_p0;
  logic [CW-1:0]   count_p1;
  logic            full_p1;
  logic            empty_p1;
  logic            vld_p1;
  logic            pop;
  logic            in_range;
  logic            fetch;

  assign in_range = ({1'b0, pc_p0} < PC_LIMIT);
  assign vld_p1   = (count_p1 != '0);
  assign pop      = vld_p1 && out_ready;
  assign fetch    = (state_p0 == RUN) && !redirect_valid && in_range &&
                    (!full_p1 || pop);
  assign fetch_p0 = '{pc: pc_p0, instr: imem_instr};

  // Fetch stage: pc register and run/halt control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0    <= RESET_PC;
      state_p0 <= RUN;
    end else if (redirect_valid) begin
      pc_p0    <= word_align(redirect_pc);
      state_p0 <= RUN;
    end else if ((state_p0 == RUN) && !in_range) begin
      state_p0 <= HALT;
    end else if (fetch) begin
      pc_p0    <= pc_p0 + XLEN'(INSTR_BYTES);
    end
  end

  // Buffer stage: fetched {pc, instr} pairs waiting for decode.
  fetch_fifo #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fetch_p0),
    .dout  (head_p1),
    .count (count_p1),
    .full  (full_p1),
    .empty (empty_p1)
  );

  // The buffer slot under the read pointer is stale once popped, so the
  // last handed-over entry is kept here to hold the outputs while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      last_p1 <= '0;
    else if (pop) last_p1 <= head_p1;
  end

  // Output stage: head entry towards decode.
  assign out_valid    = vld_p1;
  assign out_instr    = vld_p1 ? head_p1.instr : last_p1.instr;
  assign out_pc       = vld_p1 ? head_p1.pc    : last_p1.pc;
  assign out_pc_plus4 = out_pc + XLEN'(INSTR_BYTES);
  assign imem_pc      = pc_p0;
  assign halted       = (state_p0 == HALT) && empty_p1;

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch)                 perf_fetched <= sat_inc(perf_fetched);
      if (vld_p1 && !out_ready)  perf_stall   <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int IMW   = 4;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] imem [16];
  logic [31:0] prog [4];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem[imem_pc[5:2]];

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (IMW),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (imem_pc !== 32'h0) begin bad++; $display("FAIL reset_imem_pc: got %h want 0", imem_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    total++; if (out_pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_plus4: got %h want 4", out_pc_plus4); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetched !== 32'h0 || perf_stall !== 32'h0) begin bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetched, perf_stall); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Streaming with decode always ready: one instruction per cycle.
  task automatic test_sequence();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d]: got %b want 1", k, out_valid); end
      total++; if (out_pc !== 32'(4*k)) begin bad++; $display("FAIL seq_pc[%0d]: got %h want %h", k, out_pc, 32'(4*k)); end
      total++; if (out_instr !== prog[k]) begin bad++; $display("FAIL seq_instr[%0d]: got %h want %h", k, out_instr, prog[k]); end
      total++; if (out_pc_plus4 !== 32'(4*k+4)) begin bad++; $display("FAIL seq_plus4[%0d]: got %h want %h", k, out_pc_plus4, 32'(4*k+4)); end
    end
  endtask

  // Continues from test_sequence: end of memory, then redirect back to 0.
  task automatic test_halt();
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_valid[%0d]: got %b want 0", k, out_valid); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag[%0d]: got %b want 1", k, halted); end
      total++; if (imem_pc !== 32'h10) begin bad++; $display("FAIL halt_imem_pc[%0d]: got %h want 10", k, imem_pc); end
      total++; if (out_pc !== 32'hC) begin bad++; $display("FAIL halt_hold_pc[%0d]: got %h want c", k, out_pc); end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL resume_halted: got %b want 0", halted); end
    total++; if (imem_pc !== 32'h0) begin bad++; $display("FAIL resume_imem_pc: got %h want 0", imem_pc); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL resume_valid0: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== prog[0]) begin
      bad++; $display("FAIL resume_head: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", out_valid, out_pc, out_instr, prog[0]);
    end
  endtask

  // Decode stalled from reset: buffer fills to depth and everything holds.
  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (imem_pc !== ((k == 0) ? 32'h4 : 32'h8)) begin bad++; $display("FAIL bp_imem_pc[%0d]: got %h", k, imem_pc); end
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== prog[0]) begin
        bad++; $display("FAIL bp_head[%0d]: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", k, out_valid, out_pc, out_instr, prog[0]);
      end
    end
`ifdef FETCH_PERF_EN
    total++; if (perf_stall !== 32'd4) begin bad++; $display("FAIL perf_stall: got %0d want 4", perf_stall); end
    total++; if (perf_fetched !== 32'd2) begin bad++; $display("FAIL perf_fetched: got %0d want 2", perf_fetched); end
`endif
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'(4*k) || out_instr !== prog[k]) begin
        bad++; $display("FAIL bp_drain[%0d]: got v=%b pc=%h i=%h want pc=%h i=%h", k, out_valid, out_pc, out_instr, 32'(4*k), prog[k]);
      end
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetched !== 32'd4 || perf_stall !== 32'd4) begin bad++; $display("FAIL perf_final: got %0d/%0d want 4/4", perf_fetched, perf_stall); end
`endif
  endtask

  // Redirect while the buffer holds PCs 4 and 8 and the head is popping.
  task automatic test_redirect();
    do_reset();
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    total++; if (out_pc !== 32'h4 || imem_pc !== 32'hC) begin bad++; $display("FAIL redir_setup: got pc=%h imem_pc=%h want 4/c", out_pc, imem_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_000E;
    tick();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b want 0", out_valid); end
    total++; if (out_pc !== 32'h4) begin bad++; $display("FAIL redir_popped: got %h want 4", out_pc); end
    total++; if (imem_pc !== 32'hC) begin bad++; $display("FAIL redir_align: got %h want c", imem_pc); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'hC || out_instr !== prog[3] || out_pc_plus4 !== 32'h10) begin
      bad++; $display("FAIL redir_target: got v=%b pc=%h i=%h p4=%h want 1/c/%h/10", out_valid, out_pc, out_instr, out_pc_plus4, prog[3]);
    end
  endtask

  // Reset asserted mid-cycle with a full, stalled buffer acts immediately.
  task automatic test_async_reset();
    do_reset();
    repeat (3) tick();
    total++; if (out_valid !== 1'b1 || imem_pc !== 32'h8) begin bad++; $display("FAIL areset_setup: got v=%b imem_pc=%h want 1/8", out_valid, imem_pc); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    total++; if (imem_pc !== 32'h0) begin bad++; $display("FAIL areset_imem_pc: got %h want 0", imem_pc); end
    total++; if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h4) begin
      bad++; $display("FAIL areset_outs: got i=%h pc=%h p4=%h want 0/0/4", out_instr, out_pc, out_pc_plus4);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Random ready/redirect traffic against a queue-based model.
  task automatic test_random();
    logic [31:0] q_pc [$];
    logic [31:0] q_in [$];
    logic [31:0] mpc, lpc, lin, epc, ein;
    bit          mrun, pop;
    int          nfetch, nstall, r;
    do_reset();
    mpc = 32'h0; mrun = 1'b1; lpc = 32'h0; lin = 32'h0; nfetch = 0; nstall = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      if (r < 7)      redirect_pc = $urandom_range(0, 15);
      else if (r < 9) redirect_pc = $urandom_range(16, 40);
      else            redirect_pc = $urandom | 32'hF000_0000;
      pop = (q_pc.size() > 0) && out_ready;
      if ((q_pc.size() > 0) && !out_ready) nstall++;
      if (pop) begin
        lpc = q_pc.pop_front();
        lin = q_in.pop_front();
      end
      if (redirect_valid) begin
        q_pc.delete();
        q_in.delete();
        mpc = {redirect_pc[31:2], 2'b00};
        mrun = 1'b1;
      end else if (mrun) begin
        if (mpc >= 32'(IMW*4)) mrun = 1'b0;
        else if (q_pc.size() < DEPTH) begin
          q_pc.push_back(mpc);
          q_in.push_back(prog[mpc[3:2]]);
          mpc = mpc + 32'd4;
          nfetch++;
        end
      end
      tick();
      epc = (q_pc.size() > 0) ? q_pc[0] : lpc;
      ein = (q_in.size() > 0) ? q_in[0] : lin;
      total++; if (out_valid !== (q_pc.size() > 0)) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, out_valid, q_pc.size() > 0); end
      total++; if (out_pc !== epc || out_pc_plus4 !== epc + 32'd4) begin bad++; $display("FAIL rnd_pc[%0d]: got %h/%h want %h", cyc, out_pc, out_pc_plus4, epc); end
      total++; if (out_instr !== ein) begin bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", cyc, out_instr, ein); end
      total++; if (imem_pc !== mpc) begin bad++; $display("FAIL rnd_imem_pc[%0d]: got %h want %h", cyc, imem_pc, mpc); end
      total++; if (halted !== (!mrun && q_pc.size() == 0)) begin bad++; $display("FAIL rnd_halted[%0d]: got %b want %b", cyc, halted, !mrun && q_pc.size() == 0); end
    end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetched !== 32'(nfetch) || perf_stall !== 32'(nstall)) begin
      bad++; $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", perf_fetched, perf_stall, nfetch, nstall);
    end
`endif
    redirect_valid = 1'b0;
  endtask

  initial begin
    prog[0] = 32'h0000_0820;
    prog[1] = 32'h2001_000A;
    prog[2] = 32'h2002_0014;
    prog[3] = 32'h0022_1820;
    for (int i = 0; i < 16; i++) imem[i] = (i < 4) ? prog[i] : $urandom;
    test_reset();
    test_sequence();
    test_halt();
    test_backpressure();
    test_redirect();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
